// File: rtl/esp32_rom_packer.sv
// esp32_rom_packer
// Turns the byte stream coming from the ESP32 SPI link into 16-bit SDRAM
// writes. Even and odd ROM bytes are paired into words and queued in a
// small FIFO, which drains into the SDRAM port. A control register at
// 0xFF000000 drives the SNES core reset and marks the end of the image.
module esp32_rom_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_BITS  = 25
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 spi_wr,
  input  logic [31:0]          spi_addr,
  input  logic [7:0]           spi_data,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [15:0]          mem_din,
  output logic                 mem_wr,
  input  logic                 mem_busy,
  output logic                 cpu_reset,
  output logic                 load_done,
  output logic [23:0]          bytes_loaded,
  output logic                 overflow,
  output logic                 seq_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int WA_W  = ADDR_BITS - 1;   // word address width
  localparam int ENT_W = WA_W + 16;       // FIFO entry: {word address, data}
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  // Word FIFO storage and pointers
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  // Pending even byte waiting for its odd partner
  logic             pend_valid_reg;
  logic [WA_W-1:0]  pend_addr_reg;
  logic [7:0]       pend_byte_reg;

  // Control / status registers
  logic             finish_reg;
  logic             cpu_reset_reg;
  logic             load_done_reg;
  logic [23:0]      bytes_loaded_reg;
  logic             overflow_reg;
  logic             seq_err_reg;

  // Byte decode
  logic             rom_wr;
  logic             ctrl_wr;
  logic [WA_W-1:0]  spi_word_addr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;

  // Pairing results for this cycle
  logic             push_req;
  logic [ENT_W-1:0] push_word;
  logic             push_ok;
  logic             overflow_set;
  logic             seq_err_set;
  logic             pend_valid_next;
  logic [WA_W-1:0]  pend_addr_next;
  logic [7:0]       pend_byte_next;
  logic [ENT_W-1:0] head_word;

  // Control has its own address byte, so it naturally wins over ROM data
  assign ctrl_wr       = spi_wr && (spi_addr[31:24] == 8'hFF);
  assign rom_wr        = spi_wr && (spi_addr[31:24] == 8'h00);
  assign spi_word_addr = spi_addr[ADDR_BITS-1:1];

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == DEPTH_CNT);
  assign pop        = !fifo_empty && !mem_busy;

  // A full FIFO still accepts a word when the head leaves on the same edge
  assign push_ok      = push_req && (!fifo_full || pop);
  assign overflow_set = push_req && fifo_full && !pop;

  // Pair even/odd ROM bytes into words; unmatched bytes flag a sequence error
  always_comb begin
    push_req        = 1'b0;
    push_word       = '0;
    seq_err_set     = 1'b0;
    pend_valid_next = pend_valid_reg;
    pend_addr_next  = pend_addr_reg;
    pend_byte_next  = pend_byte_reg;
    if (rom_wr) begin
      if (!spi_addr[0]) begin
        // A new even byte replaces any stale one
        seq_err_set     = pend_valid_reg;
        pend_valid_next = 1'b1;
        pend_addr_next  = spi_word_addr;
        pend_byte_next  = spi_data;
      end else begin
        push_req        = 1'b1;
        pend_valid_next = 1'b0;
        if (pend_valid_reg && (pend_addr_reg == spi_word_addr)) begin
          push_word = {spi_word_addr, spi_data, pend_byte_reg};
        end else begin
          // Orphan odd byte is still written, low byte zero-filled
          push_word   = {spi_word_addr, spi_data, 8'h00};
          seq_err_set = 1'b1;
        end
      end
    end
  end

  // FIFO storage write; the array carries no reset so it maps to RAM
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= push_word;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Pending byte, control register and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid_reg   <= 1'b0;
      pend_addr_reg    <= '0;
      pend_byte_reg    <= '0;
      finish_reg       <= 1'b0;
      cpu_reset_reg    <= 1'b0;
      bytes_loaded_reg <= '0;
      overflow_reg     <= 1'b0;
      seq_err_reg      <= 1'b0;
    end else if (ctrl_wr) begin
      cpu_reset_reg <= spi_data[0];
      finish_reg    <= spi_data[1];
      if (!spi_data[1]) begin
        // Starting a new load: status restarts, queued words still drain
        pend_valid_reg   <= 1'b0;
        bytes_loaded_reg <= '0;
        overflow_reg     <= 1'b0;
        seq_err_reg      <= 1'b0;
      end
    end else begin
      pend_valid_reg <= pend_valid_next;
      pend_addr_reg  <= pend_addr_next;
      pend_byte_reg  <= pend_byte_next;
      if (rom_wr && (bytes_loaded_reg != 24'hFF_FFFF)) begin
        bytes_loaded_reg <= bytes_loaded_reg + 24'd1;
      end
      if (overflow_set) begin
        overflow_reg <= 1'b1;
      end
      if (seq_err_set) begin
        seq_err_reg <= 1'b1;
      end
    end
  end

  // Load is complete once finished, drained and nothing is half-paired
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_done_reg <= 1'b0;
    end else begin
      load_done_reg <= finish_reg && fifo_empty && !pend_valid_reg;
    end
  end

  // The FIFO head is read asynchronously so a pushed word is presented
  // the very next cycle; outputs are zero while nothing is queued.
  assign head_word    = fifo_mem[rd_ptr_reg];
  assign mem_wr       = !fifo_empty;
  assign mem_addr     = fifo_empty ? '0 : {head_word[ENT_W-1:16], 1'b0};
  assign mem_din      = fifo_empty ? '0 : head_word[15:0];

  assign cpu_reset    = cpu_reset_reg;
  assign load_done    = load_done_reg;
  assign bytes_loaded = bytes_loaded_reg;
  assign overflow     = overflow_reg;
  assign seq_err      = seq_err_reg;

endmodule

// File: doc/esp32_rom_packer.md
ESP32_ROM_PACKER -- requirements
Module: esp32_rom_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, word FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter ADDR_BITS, default 25, memory byte-address width.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port spi_wr  in  1  one-cycle strobe, one received SPI byte.
REQ-006 SHALL have port spi_addr  in  32  byte address of the received byte.
REQ-007 SHALL have port spi_data  in  8  received byte.
REQ-008 SHALL have port mem_addr  out  ADDR_BITS  SDRAM byte address, bit0 always 0.
REQ-009 SHALL have port mem_din  out  16  SDRAM write word, {odd byte, even byte}.
REQ-010 SHALL have port mem_wr  out  1  SDRAM write request.
REQ-011 SHALL have port mem_busy  in  1  SDRAM busy; request not accepted while high.
REQ-012 SHALL have port cpu_reset  out  1  hold SNES core in reset (control bit0).
REQ-013 SHALL have port load_done  out  1  image fully written to SDRAM.
REQ-014 SHALL have port bytes_loaded  out  24  accepted ROM byte count, saturating.
REQ-015 SHALL have port overflow  out  1  sticky, word dropped on full FIFO.
REQ-016 SHALL have port seq_err  out  1  sticky, byte pairing violated.

Function
REQ-017 SHALL decode spi_wr bytes: spi_addr[31:24]=0x00 ROM data; 0xFF control; all others ignored.
REQ-018 SHALL, on ROM even byte (addr[0]=0) with no pending byte, latch byte and addr[ADDR_BITS-1:1] as pending.
REQ-019 SHALL, on ROM odd byte whose addr[ADDR_BITS-1:1] matches pending, form word {odd, pending}, push to FIFO, clear pending.
REQ-020 SHALL, on even byte while pending exists, drop old pending, latch new one, set seq_err.
REQ-021 SHALL, on odd byte with no/mismatched pending, push {odd, 0x00} at its own word address, set seq_err, clear pending.
REQ-022 SHALL increment bytes_loaded per accepted ROM byte, saturating at 0xFFFFFF.
REQ-023 SHALL, on push with FIFO full and no pop same cycle, drop word and set overflow; push with simultaneous pop SHALL succeed.
REQ-024 SHALL drain FIFO head: mem_wr=1 with mem_addr/mem_din = head whenever FIFO non-empty.
REQ-025 SHALL treat request accepted in a cycle with mem_wr=1 and mem_busy=0; head popped on that edge; outputs held stable otherwise.
REQ-026 SHALL show mem_wr=1 the cycle after the push edge into an empty FIFO (1-cycle latency).
REQ-027 SHALL sustain one accepted word per cycle while mem_busy=0 and FIFO non-empty.
REQ-028 SHALL, on control write, set cpu_reset=spi_data[0] and finish flag=spi_data[1].
REQ-029 SHALL, on control write with spi_data[1]=0, clear bytes_loaded, overflow, seq_err, pending (FIFO contents kept).
REQ-030 SHALL drive load_done=1 iff finish flag=1, FIFO empty, no pending byte; registered, 1-cycle delay.
REQ-031 SHALL, on control write and ROM byte same cycle (impossible from single SPI source), give control priority; ROM byte ignored.

Reset
REQ-032 SHALL, on reset_n=0, asynchronously clear FIFO, pending, finish flag; mem_wr=0, mem_addr=0, mem_din=0, cpu_reset=0, load_done=0, bytes_loaded=0, overflow=0, seq_err=0.
REQ-033 SHALL discard in-flight FIFO words on reset mid-operation; no mem_wr until next push after reset_n=1.

Verification
REQ-034 SHALL verify: bytes 0x34@0x000000, 0x12@0x000001, mem_busy=0 -> mem_wr one cycle later, mem_addr=0, mem_din=0x1234, bytes_loaded=2.
REQ-035 SHALL verify: mem_busy=1 held, 5 byte pairs pushed (depth 4) -> 4 words stored, overflow=1; release busy -> 4 writes in order, addr 0,2,4,6.
REQ-036 SHALL verify: odd byte 0xAB@0x000011 alone -> mem_din=0xAB00, mem_addr=0x10, seq_err=1.
REQ-037 SHALL verify: control write 0x03@0xFF000000 after last word accepted -> cpu_reset=1, load_done=1 next cycle; write 0x00 -> load_done=0, bytes_loaded=0, cpu_reset=0.
REQ-038 SHALL verify: reset_n pulsed low with 3 words queued -> mem_wr=0 immediately, no writes after release.
REQ-039 SHALL verify: bytes at 0x05000000 and 0x00000000 (even, never paired) with finish=1 -> no write, load_done stays 0.
